// File: rtl/jogo_memoria_parametrizado.sv
// jogo_memoria_parametrizado: Simon-style memory game with LFSR-grown sequence, preview and timed player entry.
module jogo_memoria_parametrizado #(
    parameter int          N_BOTOES  = 4,
    parameter int          N_RODADAS = 16,
    parameter int          T_LED     = 1000,
    parameter int          T_PAUSA   = 250,
    parameter int          T_TIMEOUT = 5000,
    parameter logic [15:0] SEMENTE   = 16'hACE1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               jogar,
    input  logic                               modo,
    input  logic [N_BOTOES-1:0]                botoes,
    output logic [N_BOTOES-1:0]                leds,
    output logic                               ganhou,
    output logic                               perdeu,
    output logic                               timeout,
    output logic                               pronto,
    output logic [3:0]                         db_estado,
    output logic [$clog2(N_RODADAS+1)-1:0]     db_rodada,
    output logic [$clog2(N_RODADAS+1)-1:0]     db_indice
);
    localparam int LB   = $clog2(N_BOTOES);
    localparam int RW   = $clog2(N_RODADAS + 1);
    localparam int IW   = N_RODADAS > 1 ? $clog2(N_RODADAS) : 1;
    localparam int TM1  = T_LED > T_PAUSA ? T_LED : T_PAUSA;
    localparam int TMAX = TM1 > T_TIMEOUT ? TM1 : T_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ACRESCENTA  = 4'h2,
        MOSTRA      = 4'h3,
        PAUSA       = 4'h4,
        ESPERA      = 4'h5,
        COMPARA     = 4'h6,
        PROX_JOGADA = 4'h7,
        PROX_RODADA = 4'h8,
        FIM_GANHOU  = 4'hA,
        FIM_PERDEU  = 4'hB,
        FIM_TIMEOUT = 4'hC
    } t_estado;

    t_estado             r_estado, w_prox;
    logic [TW-1:0]       r_tmr;
    logic [15:0]         r_lfsr;
    logic [RW-1:0]       r_rodada, r_indice;
    logic [N_BOTOES-1:0] r_jog;
    logic                r_ant;
    logic [LB-1:0]       r_mem [N_RODADAS];

    logic                w_ultimo, w_jogada, w_fb;
    logic [N_BOTOES-1:0] w_elem;

    assign w_ultimo = r_indice == r_rodada - 1'b1;
    assign w_jogada = |botoes & ~r_ant;
    assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_elem   = N_BOTOES'(1) << r_mem[IW'(r_indice)];

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            INICIAL:     w_prox = jogar ? PREPARA : INICIAL;
            PREPARA:     w_prox = ACRESCENTA;
            ACRESCENTA:  w_prox = MOSTRA;
            MOSTRA:      w_prox = r_tmr == TW'(T_LED - 1) ? PAUSA : MOSTRA;
            PAUSA:       w_prox = r_tmr != TW'(T_PAUSA - 1) ? PAUSA : w_ultimo ? ESPERA : MOSTRA;
            ESPERA:      w_prox = w_jogada ? COMPARA : r_tmr == TW'(T_TIMEOUT - 1) ? FIM_TIMEOUT : ESPERA;
            COMPARA:     w_prox = r_jog != w_elem ? FIM_PERDEU : !w_ultimo ? PROX_JOGADA :
                                  r_rodada == RW'(N_RODADAS) ? FIM_GANHOU : PROX_RODADA;
            PROX_JOGADA: w_prox = ESPERA;
            PROX_RODADA: w_prox = botoes == '0 ? ACRESCENTA : PROX_RODADA;
            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: w_prox = jogar ? PREPARA : r_estado;
            default:     w_prox = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= INICIAL;
            r_tmr    <= '0;
            r_lfsr   <= SEMENTE;
            r_rodada <= '0;
            r_indice <= '0;
            r_jog    <= '0;
            r_ant    <= 1'b0;
        end else begin
            r_estado <= w_prox;
            // every state change restarts the timer, so each timed state counts from zero
            r_tmr    <= w_prox != r_estado ? '0 : r_tmr + 1'b1;
            r_ant    <= |botoes;
            if (r_estado == PREPARA && !modo)
                r_lfsr <= SEMENTE;
            else if (modo || r_estado == ACRESCENTA)
                r_lfsr <= {r_lfsr[14:0], w_fb};
            if (r_estado == ESPERA)
                r_jog <= botoes;
            if (r_estado == PREPARA)
                r_rodada <= RW'(1);
            if (r_estado == PREPARA || r_estado == ACRESCENTA)
                r_indice <= '0;
            if (r_estado == PAUSA && w_prox != PAUSA)
                r_indice <= w_ultimo ? '0 : r_indice + 1'b1;
            if (r_estado == PROX_JOGADA)
                r_indice <= r_indice + 1'b1;
            if (r_estado == PROX_RODADA && w_prox == ACRESCENTA)
                r_rodada <= r_rodada + 1'b1;
        end
    end

    always_ff @(posedge clock)
        if (!reset && r_estado == ACRESCENTA)
            r_mem[IW'(r_rodada - 1'b1)] <= r_lfsr[LB-1:0];

    assign leds      = r_estado == MOSTRA ? w_elem :
                       (r_estado == ESPERA || r_estado == PROX_JOGADA || r_estado == PROX_RODADA) ? botoes : '0;
    assign ganhou    = r_estado == FIM_GANHOU;
    assign perdeu    = r_estado == FIM_PERDEU || r_estado == FIM_TIMEOUT;
    assign timeout   = r_estado == FIM_TIMEOUT;
    assign pronto    = ganhou || perdeu;
    assign db_estado = r_estado;
    assign db_rodada = r_rodada;
    assign db_indice = r_indice;
endmodule
